// File: rtl/eight_data_compress_unit.sv
// Packs the significant bytes of eight 32-bit words, MSB-aligned, into one 256-bit
// result. Each word also gets a 2-bit size tag, and the block gets a total byte length.
module eight_data_compress_unit #(
  parameter bit DEBUG_BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wrtEn,
  input  logic [255:0] dataIn,
  input  logic [255:0] cprDataIn,
  input  logic [15:0]  tagIn,
  output logic [255:0] dataOut,
  output logic [15:0]  tagOut,
  output logic [7:0]   lenOut
);

  // wrtEn is a valid-only strobe: the block present at an edge with wrtEn=1 is
  // always accepted, and there is no ready/backpressure path.

  logic [15:0]  w_class_tags;
  logic [15:0]  w_sel_tags;
  logic [255:0] w_sel_data;
  logic [255:0] w_packed;
  logic [5:0]   w_len;

  logic [255:0] r_data;
  logic [15:0]  r_tag;
  logic [7:0]   r_len;

  always_comb begin
    logic [31:0] word;
    w_class_tags = '0;
    word         = '0;
    for (int i = 0; i < 8; i++) begin
      word = dataIn[32*i +: 32];
      if (word == 32'd0)
        w_class_tags[2*i +: 2] = 2'b00;
      else if (word[23:0] == 24'd0)
        w_class_tags[2*i +: 2] = 2'b01;
      else if (word[15:0] == 16'd0)
        w_class_tags[2*i +: 2] = 2'b10;
      else
        w_class_tags[2*i +: 2] = 2'b11;
    end
  end

  assign w_sel_tags = DEBUG_BYPASS ? tagIn     : w_class_tags;
  assign w_sel_data = DEBUG_BYPASS ? cprDataIn : dataIn;

  // Word 7 lands first; each word's kept bytes are top-aligned, then shifted
  // down by the running byte offset of everything packed before it.
  always_comb begin
    logic [31:0] kept;
    logic [31:0] word;
    logic [5:0]  nbytes;
    logic [5:0]  off;
    w_packed = '0;
    kept     = '0;
    word     = '0;
    nbytes   = '0;
    off      = '0;
    for (int i = 7; i >= 0; i--) begin
      word = w_sel_data[32*i +: 32];
      case (w_sel_tags[2*i +: 2])
        2'b00:   begin kept = 32'd0;                  nbytes = 6'd0; end
        2'b01:   begin kept = {word[31:24], 24'd0};   nbytes = 6'd1; end
        2'b10:   begin kept = {word[31:16], 16'd0};   nbytes = 6'd2; end
        default: begin kept = word;                   nbytes = 6'd4; end
      endcase
      w_packed = w_packed | ({kept, 224'd0} >> {off, 3'b000});
      off      = off + nbytes;
    end
    w_len = off;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_tag  <= '0;
      r_len  <= '0;
    end else if (wrtEn) begin
      r_data <= w_packed;
      r_tag  <= w_sel_tags;
      r_len  <= {2'b00, w_len};
    end
  end

  assign dataOut = r_data;
  assign tagOut  = r_tag;
  assign lenOut  = r_len;

endmodule

// File: tb/tb_eight_data_compress_unit.sv
// Bench for eight_data_compress_unit: one bypass instance and one classifier instance,
// checked against a byte-queue reference model.
module tb_eight_data_compress_unit;

  logic         clk;
  logic         reset;
  logic         wrtEn;
  logic [255:0] dataIn;
  logic [255:0] cprDataIn;
  logic [15:0]  tagIn;

  logic [255:0] byp_data, cls_data;
  logic [15:0]  byp_tag,  cls_tag;
  logic [7:0]   byp_len,  cls_len;

  int n_checks;
  int n_pass;

  // {data, tag, len} per expected capture; bypass entry pushed before classifier entry
  logic [279:0] exp_q[$];
  logic [279:0] held_b;
  logic [279:0] held_c;

  eight_data_compress_unit #(.DEBUG_BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .dataIn(dataIn), .cprDataIn(cprDataIn),
    .tagIn(tagIn), .dataOut(byp_data), .tagOut(byp_tag), .lenOut(byp_len)
  );

  eight_data_compress_unit #(.DEBUG_BYPASS(1'b0)) u_cls (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .dataIn(dataIn), .cprDataIn(cprDataIn),
    .tagIn(tagIn), .dataOut(cls_data), .tagOut(cls_tag), .lenOut(cls_len)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model
  function automatic logic [1:0] classify(input logic [31:0] w);
    if (w == 0)                   return 2'd0;
    else if (w % (1 << 24) == 0)  return 2'd1;
    else if (w % (1 << 16) == 0)  return 2'd2;
    else                          return 2'd3;
  endfunction

  function automatic logic [279:0] model(input logic [255:0] words, input logic [15:0] tags);
    logic [7:0]   q[$];
    logic [255:0] res;
    logic [31:0]  w;
    int           nb;
    int           t;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      w  = words[32*i +: 32];
      t  = int'(tags[2*i +: 2]);
      nb = (t == 0) ? 0 : (t == 1) ? 1 : (t == 2) ? 2 : 4;
      for (int b = 0; b < nb; b++) q.push_back(w[31-8*b -: 8]);
    end
    for (int k = 0; k < q.size(); k++) res[255-8*k -: 8] = q[k];
    return {res, tags, 8'(q.size())};
  endfunction

  function automatic logic [15:0] class_tags(input logic [255:0] words);
    logic [15:0] t;
    for (int i = 0; i < 8; i++) t[2*i +: 2] = classify(words[32*i +: 32]);
    return t;
  endfunction

  task automatic compare_all(input string name);
    check({name, "_byp_data"}, byp_data, held_b[279:24]);
    check({name, "_byp_tag"},  256'(byp_tag), 256'(held_b[23:8]));
    check({name, "_byp_len"},  256'(byp_len), 256'(held_b[7:0]));
    check({name, "_cls_data"}, cls_data, held_c[279:24]);
    check({name, "_cls_tag"},  256'(cls_tag), 256'(held_c[23:8]));
    check({name, "_cls_len"},  256'(cls_len), 256'(held_c[7:0]));
  endtask

  // driver: one clock with the current inputs, then compare against the model
  task automatic cycle(input logic we, input string name);
    wrtEn = we;
    if (we && reset) begin
      exp_q.push_back(model(cprDataIn, tagIn));
      exp_q.push_back(model(dataIn, class_tags(dataIn)));
    end
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      held_b = exp_q.pop_front();
      held_c = exp_q.pop_front();
    end
    compare_all(name);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return {w[31:24], 24'd0};
      2:       return {w[31:16], 16'd0};
      default: return w;
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < 8; i++) begin
      dataIn[32*i +: 32]    = rand_word();
      cprDataIn[32*i +: 32] = $urandom;
    end
    tagIn = 16'($urandom);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    held_b    = '0;
    held_c    = '0;
    reset     = 1'b0;
    wrtEn     = 1'b0;
    dataIn    = '0;
    cprDataIn = '0;
    tagIn     = '0;

    #2;
    compare_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // mixed block
    cprDataIn = {32'h1200_0000, 32'h0000_0000, 32'h3400_0000, 32'h5678_0000,
                 32'h9ABC_DEF1, 32'h2300_0000, 32'h4567_0000, 32'h89AB_CDEF};
    tagIn     = 16'b0100011011011011;
    dataIn    = cprDataIn;
    cycle(1'b1, "mixed");
    check("mixed_len_const", 256'(byp_len), 256'h0F);
    check("mixed_data_const", byp_data, {120'h123456789ABCDEF123456789ABCDEF, 136'd0});

    cprDataIn = {32'h1234_0000, 32'h5678_0000, 32'h9ABC_0000, 32'hDE00_0000,
                 32'hF100_0000, 32'h2345_0000, 32'h6700_0000, 32'h0000_0000};
    tagIn     = 16'b1010100101100100;
    cycle(1'b1, "blk2");
    check("blk2_len_const", 256'(byp_len), 256'h0B);
    check("blk2_data_const", byp_data, {88'h123456789ABCDEF1234567, 168'd0});

    cprDataIn = {32'h1234_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    cprDataIn[63:0] = {32'h5678_0000, 32'h9ABC_DEF1};
    tagIn     = 16'b1000000000001011;
    cycle(1'b1, "sparse");
    check("sparse_len_const", 256'(byp_len), 256'h08);
    check("sparse_data_const", byp_data, {64'h123456789ABCDEF1, 192'd0});

    cprDataIn = '0;
    tagIn     = '0;
    dataIn    = '0;
    cycle(1'b1, "all_zero");
    check("zero_len_const", 256'(byp_len), 256'd0);

    rand_inputs();
    tagIn = 16'hFFFF;
    cycle(1'b1, "all_ones");
    check("full_len_const", 256'(byp_len), 256'h20);
    check("full_data_copy", byp_data, cprDataIn);

    // classifier directed: tags 00/01/10/11 twice
    dataIn    = {32'd0, 32'h1200_0000, 32'h1234_0000, 32'h0000_0012,
                 32'd0, 32'h1200_0000, 32'h1234_0000, 32'h0000_0012};
    cprDataIn = dataIn;
    tagIn     = 16'h1B1B;
    cycle(1'b1, "classify");
    check("cls_tag_const", 256'(cls_tag), 256'h1B1B);
    check("cls_len_const", 256'(cls_len), 256'd14);
    check("cls_data_const", cls_data, {112'h12_1234_0000_0012_12_1234_0000_0012, 144'd0});

    // hold with wrtEn low
    rand_inputs();
    cycle(1'b0, "hold1");
    rand_inputs();
    cycle(1'b0, "hold2");

    // randomized stream
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      cycle(($urandom_range(0, 3) != 0), "rand");
    end

    // reset between edges discards the in-flight block
    rand_inputs();
    cycle(1'b1, "pre_rst");
    rand_inputs();
    wrtEn = 1'b1;
    #3;
    reset  = 1'b0;
    held_b = '0;
    held_c = '0;
    #1;
    compare_all("async_rst");
    @(posedge clk); #1;
    compare_all("rst_held");
    reset = 1'b1;
    rand_inputs();
    cycle(1'b1, "post_rst");
    rand_inputs();
    cycle(1'b1, "post_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eight_data_compress_unit.md
Name: eight_data_compress_unit

Overview:
- Compresses a 256-bit block of eight 32-bit words into a byte-packed, MSB-aligned stream.
- Each word gets a 2-bit size tag, and the block gets a total compressed byte length.
- Sits in the compression datapath between the raw data source and the stream assembler.
- A debug path lets the bench inject pre-classified words and tags, bypassing the internal classifier.

Parameters:
- DEBUG_BYPASS, 1, when 1 the packer consumes cprDataIn/tagIn; when 0 it consumes the internal classification of dataIn.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wrtEn  input  1  when 1, capture and compress the current block this cycle.
- dataIn  input  256  raw block; word i = bits [32i+31:32i], word 7 is most significant.
- cprDataIn  input  256  debug: pre-classified words, same word layout as dataIn.
- tagIn  input  16  debug: tag i = bits [2i+1:2i].
- dataOut  output  256  packed significant bytes, MSB-aligned, zero-padded.
- tagOut  output  16  tags used for the captured block.
- lenOut  output  8  total compressed length in bytes, range 0..32.

Behaviour:
- Tag encoding:
  - 00 = word is zero, keeps 0 bytes.
  - 01 = keeps the top byte [31:24].
  - 10 = keeps the top two bytes [31:16].
  - 11 = keeps all 4 bytes.
- Internal classifier (used when DEBUG_BYPASS=0), per word:
  - word==0 gives 00.
  - else low 24 bits zero gives 01.
  - else low 16 bits zero gives 10.
  - else 11.
  - Example: 0x0000_0012 classifies as 11.
- In bypass mode, bytes a tag does not keep are don't-care; they never reach dataOut.
- Packing:
  - Concatenate the kept bytes of word 7, then word 6, down to word 0.
  - Within each word, take bytes from most significant to least.
  - Place the result starting at dataOut[255:248].
  - Every byte position at or beyond lenOut is 0.
- lenOut = sum over the 8 words of bytes(tag), with bytes = {0,1,2,4}. Zero-extend the sum to 8 bits; the maximum is 32 (0x20).
- tagOut = the selected tags, unchanged.
- Timing:
  - On the rising edge with wrtEn=1, dataOut/tagOut/lenOut register the result for the inputs at that edge.
  - Latency is 1 cycle; a new block can be accepted every cycle.
  - The compute path is purely combinational before the output register.
- wrtEn=0: outputs hold their previous values.
- Reset:
  - While reset=0 (asynchronous), dataOut=0, tagOut=0, lenOut=0, independent of clk and wrtEn.
  - A reset asserted mid-stream discards the in-flight result.
  - The first capture after release happens on the first rising edge with reset=1 and wrtEn=1.
- No handshake or backpressure; there is no X-propagation requirement on unused inputs.

Test Plan:
- Mixed block: cprDataIn=1200_0000 0000_0000 3400_0000 5678_0000 9ABC_DEF1 2300_0000 4567_0000 89AB_CDEF (word7..0), tagIn=0100011011011011 -> lenOut=0x0F; dataOut=0x123456789ABCDEF123456789ABCDEF followed by zero fill; tagOut=tagIn.
- cprDataIn=1234_0000 5678_0000 9ABC_0000 DE00_0000 F100_0000 2345_0000 6700_0000 0000_0000, tagIn=1010100101100100 -> lenOut=0x0B; dataOut top 11 bytes=123456789ABCDEF1234567, rest 0.
- Sparse block: tagIn=1000000000001011 with words 1234_0000, six zeros, 5678_0000, 9ABC_DEF1 -> lenOut=0x08; dataOut top 8 bytes=123456789ABCDEF1.
- Boundaries:
  - All-zero words with tagIn=0 -> lenOut=0, dataOut=0.
  - tagIn=all ones -> lenOut=0x20, dataOut=cprDataIn.
- Classifier mode (DEBUG_BYPASS=0): dataIn word values 0, 0x12000000, 0x12340000, 0x00000012 -> tags 00/01/10/11 respectively; lenOut and packing match the bypass results.
- Control:
  - Drop wrtEn for 2 cycles -> outputs hold.
  - Assert reset between edges -> outputs clear immediately.
  - After release -> the next enabled edge loads the new block.
